hub75_row_fetch: RTL and testbench

Upstream feeder for the HUB75 row shifter. On a row request it reads one half-row pair (top row r, bottom row r+32) from the RGB888 framebuffer RAM and extracts one bit-plane per colour. It streams 64 column beats of {r0,g0,b0} and {r1,g1,b1} over a valid/ready handshake. The shifter consumes each beat on one clk_out edge and asserts latch after the beat marked last.

---
 rtl/hub75_pkg.sv | 30 +++
 rtl/hub75_skid_buf.sv | 50 +++++
 rtl/hub75_row_fetch.sv | 139 +++++++++++++
 tb/tb_hub75_row_fetch.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared constants, FSM encoding and bit-plane extraction for the HUB75 row feeder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hub75_pkg;

  localparam int COLS      = 64;
  localparam int HALF_ROWS = 32;
  localparam int ADDR_W    = 5;
  localparam int COL_W     = 6;
  localparam int MEM_AW    = 12;
  localparam int PLANE_W   = 3;

  // Bit offsets of each colour channel inside an RGB888 framebuffer word
  localparam int R_OFF = 16;
  localparam int G_OFF = 8;
  localparam int B_OFF = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;

  // Pull one bit-plane out of an RGB888 word as {R,G,B}
  function automatic logic [2:0] plane_bits(input logic [23:0] px, input logic [PLANE_W-1:0] plane);
    logic [23:0] sh;
    sh = px >> plane;
    return {sh[R_OFF], sh[G_OFF], sh[B_OFF]};
  endfunction

endpackage

// File: rtl/hub75_skid_buf.sv
// Two-entry FIFO holding extracted pixel beats between RAM return and the shifter.
// Latency: a push is visible at dout the cycle after it is written.
// Backpressure: full/empty exported; a push while full is only taken with a same-cycle pop.
module hub75_skid_buf #(
  parameter int W = 7
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         push_ok;
  logic         pop_ok;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign dout_o  = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; simultaneous push and pop leave occupancy unchanged
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/hub75_row_fetch.sv
// Reads one top/bottom half-row pair from the framebuffer and streams 64 bit-plane beats.
// Latency: first beat valid 2 cycles after request accept; done 66 cycles after accept at full rate.
// Backpressure: px_ready stalls the skid buffer; RAM reads throttle so at most 2 beats are outstanding.
module hub75_row_fetch
  import hub75_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_row,
  input  logic [PLANE_W-1:0] req_plane,
  output logic [MEM_AW-1:0]  mem_addr_top,
  output logic [MEM_AW-1:0]  mem_addr_bot,
  output logic               mem_rd,
  input  logic [23:0]        mem_data_top,
  input  logic [23:0]        mem_data_bot,
  output logic               px_valid,
  input  logic               px_ready,
  output logic [2:0]         px_rgb0,
  output logic [2:0]         px_rgb1,
  output logic               px_last,
  output logic               done
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  row_q, row_d;
  logic [PLANE_W-1:0] plane_q, plane_d;
  logic [COL_W:0]     issue_col_q, issue_col_d;   // one extra bit so it can rest at COLS
  logic [COL_W-1:0]   beat_col_q, beat_col_d;
  logic               done_q, done_d;
  logic               rd_vld_q;                    // read issued last cycle, data on the bus now
  logic [COL_W-1:0]   rd_col_q;                    // column of that read

  logic               pop;
  logic               skid_full, skid_empty;
  logic [6:0]         skid_din, skid_dout;
  logic [1:0]         skid_occ;
  logic [2:0]         credit;
  logic [MEM_AW-1:0]  col_ext, top_row_ext, bot_row_ext;

  assign req_ready = (state_q == IDLE);
  assign done      = done_q;
  assign pop       = px_valid & px_ready;

  // A beat leaving this cycle frees its slot, so it is subtracted; otherwise a
  // steady stream would stall every other cycle with only two slots.
  assign skid_occ = skid_full ? 2'd2 : (skid_empty ? 2'd0 : 2'd1);
  assign credit   = 3'(skid_occ) + 3'(rd_vld_q) - 3'(pop);

  // Addresses at full RAM width: row*COLS + col, bottom row offset by HALF_ROWS
  assign col_ext      = MEM_AW'(issue_col_q[COL_W-1:0]);
  assign top_row_ext  = MEM_AW'(row_q);
  assign bot_row_ext  = MEM_AW'(row_q) + MEM_AW'(HALF_ROWS);
  assign mem_addr_top = mem_rd ? ((top_row_ext << COL_W) | col_ext) : '0;
  assign mem_addr_bot = mem_rd ? ((bot_row_ext << COL_W) | col_ext) : '0;

  assign skid_din = {plane_bits(mem_data_top, plane_q),
                     plane_bits(mem_data_bot, plane_q),
                     (rd_col_q == COL_W'(COLS - 1))};

  hub75_skid_buf #(.W(7)) u_skid (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (rd_vld_q),
    .pop_i   (pop),
    .din_i   (skid_din),
    .dout_o  (skid_dout),
    .full_o  (skid_full),
    .empty_o (skid_empty)
  );

  assign px_valid = ~skid_empty;
  assign px_rgb0  = px_valid ? skid_dout[6:4] : 3'b000;
  assign px_rgb1  = px_valid ? skid_dout[3:1] : 3'b000;
  assign px_last  = px_valid & skid_dout[0];

  // Next-state, read issue and counter updates
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    plane_d     = plane_q;
    issue_col_d = issue_col_q;
    beat_col_d  = beat_col_q;
    done_d      = 1'b0;
    mem_rd      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d     = FETCH;
          row_d       = req_row;
          plane_d     = req_plane;
          issue_col_d = '0;
          beat_col_d  = '0;
        end
      end
      FETCH: begin
        if ((issue_col_q < (COL_W + 1)'(COLS)) && (credit < 3'd2)) begin
          mem_rd      = 1'b1;
          issue_col_d = issue_col_q + 1'b1;
        end
        if (pop) begin
          beat_col_d = beat_col_q + 1'b1;
          if (px_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers; reset discards any read still in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      plane_q     <= '0;
      issue_col_q <= '0;
      beat_col_q  <= '0;
      done_q      <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_col_q    <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      plane_q     <= plane_d;
      issue_col_q <= issue_col_d;
      beat_col_q  <= beat_col_d;
      done_q      <= done_d;
      rd_vld_q    <= mem_rd;
      if (mem_rd) begin
        rd_col_q <= issue_col_q[COL_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_hub75_row_fetch.sv
// Directed bench for hub75_row_fetch with a one-cycle-latency framebuffer model.
// Latency: checks first beat and done timing relative to the accept edge.
// Backpressure: drives px_ready steady or from an LFSR and checks hold/credit behaviour.
module tb_hub75_row_fetch;
  import hub75_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_row;
  logic [2:0]  req_plane;
  logic [11:0] mem_addr_top, mem_addr_bot;
  logic        mem_rd;
  logic [23:0] mem_data_top, mem_data_bot;
  logic        px_valid, px_ready;
  logic [2:0]  px_rgb0, px_rgb1;
  logic        px_last, done;

  always #20 clk = ~clk;

  hub75_row_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_row      (req_row),
    .req_plane    (req_plane),
    .mem_addr_top (mem_addr_top),
    .mem_addr_bot (mem_addr_bot),
    .mem_rd       (mem_rd),
    .mem_data_top (mem_data_top),
    .mem_data_bot (mem_data_bot),
    .px_valid     (px_valid),
    .px_ready     (px_ready),
    .px_rgb0      (px_rgb0),
    .px_rgb1      (px_rgb1),
    .px_last      (px_last),
    .done         (done)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int ram_mode, cur_row, cur_plane, rd_col, beat_col, outstanding;
  int acc_cnt, acc_cyc, first_vld_cyc, done_cyc, beats, last_cnt, last_top, last_bot;
  bit prev_last, hold_chk, seen_vld;
  logic [6:0]  held;
  logic [15:0] lfsr = 16'hACE1;

  // mode 0: word = address with bit 23 set on even addresses; mode 1: fixed top/bottom words
  function automatic logic [23:0] ram_word(input int addr, input bit bot);
    logic [11:0] a;
    a = addr[11:0];
    if (ram_mode == 1) return bot ? 24'h010100 : 24'h000001;
    return {~a[0], 11'b0, a};
  endfunction

  function automatic logic [2:0] exp_bits(input logic [23:0] w, input int p);
    logic [23:0] s;
    s = w >> p;
    return {s[16], s[8], s[0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    outstanding = 0; rd_col = 0; beat_col = 0;
    prev_last = 0; hold_chk = 0; seen_vld = 0;
  endtask

  // One clock: check the cycle at negedge+1, then model the RAM return after the edge
  task automatic tick();
    logic        rd, pop;
    logic [11:0] at, ab;
    logic [23:0] w0, w1;
    #1;
    if (hold_chk) begin
      chk("hold_vld", 32'(px_valid), 32'd1);
      chk("hold_dat", 32'({px_rgb0, px_rgb1, px_last}), 32'(held));
    end
    chk("done", 32'(done), 32'(prev_last));
    if (done) begin
      done_cyc = cyc;
      chk("rdy_at_done", 32'(req_ready), 32'd1);
    end
    if (px_valid && !seen_vld) begin
      seen_vld = 1; first_vld_cyc = cyc;
    end
    pop = px_valid & px_ready;
    rd = mem_rd; at = mem_addr_top; ab = mem_addr_bot;
    if (rd) begin
      chk("addr_top", 32'(at), 32'(cur_row * 64 + rd_col));
      chk("addr_bot", 32'(ab), 32'((cur_row + 32) * 64 + rd_col));
      chk("credit", 32'((outstanding - int'(pop)) < 2), 32'd1);
      chk("col_range", 32'(rd_col < 64), 32'd1);
      last_top = int'(at); last_bot = int'(ab);
      rd_col++;
    end
    if (pop) begin
      w0 = ram_word(cur_row * 64 + beat_col, 1'b0);
      w1 = ram_word((cur_row + 32) * 64 + beat_col, 1'b1);
      chk("rgb0", 32'(px_rgb0), 32'(exp_bits(w0, cur_plane)));
      chk("rgb1", 32'(px_rgb1), 32'(exp_bits(w1, cur_plane)));
      chk("last", 32'(px_last), 32'(beat_col == 63));
      if (px_last) last_cnt++;
      beats++; beat_col++;
    end
    hold_chk = px_valid && !px_ready;
    held = {px_rgb0, px_rgb1, px_last};
    prev_last = pop && px_last;
    outstanding = outstanding + int'(rd) - int'(pop);
    if (req_valid && req_ready) begin
      acc_cnt++; acc_cyc = cyc;
      cur_row = int'(req_row); cur_plane = int'(req_plane);
      rd_col = 0; beat_col = 0; seen_vld = 0;
    end
    @(posedge clk); #1;
    if (rd) begin
      mem_data_top = ram_word(int'(at), 1'b0);
      mem_data_bot = ram_word(int'(ab), 1'b1);
    end
    @(negedge clk);
    cyc++;
  endtask

  // Run until a done pulse is seen or the cycle budget runs out
  task automatic run_to_done(input bit lfsr_rdy);
    int n;
    n = 0;
    done_cyc = -1;
    while (done_cyc < 0 && n < 400) begin
      if (lfsr_rdy) begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        px_ready = lfsr[0];
      end
      tick();
      n++;
    end
    chk("done_seen", 32'(done_cyc >= 0), 32'd1);
  endtask

  task automatic start_req(input int row, input int plane);
    req_row = row[4:0]; req_plane = plane[2:0]; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    int acc0, d1;
    rst = 1'b0; req_valid = 1'b0; req_row = '0; req_plane = '0; px_ready = 1'b1;
    mem_data_top = '0; mem_data_bot = '0; ram_mode = 0; cur_row = 0; cur_plane = 0;
    acc_cnt = 0; acc_cyc = 0; first_vld_cyc = 0; done_cyc = -1; beats = 0; last_cnt = 0;
    last_top = 0; last_bot = 0; held = '0;
    clear_model();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_addr", 32'({mem_addr_top, mem_addr_bot}), 32'd0);
    chk("rst_px", 32'({px_valid, px_rgb0, px_rgb1, px_last, done}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Row 0, plane 7, full rate: bit 23 set on even words makes rgb toggle
    ram_mode = 0; beats = 0; last_cnt = 0;
    start_req(0, 7);
    run_to_done(1'b0);
    chk("a_beats", 32'(beats), 32'd64);
    chk("a_last_cnt", 32'(last_cnt), 32'd1);
    chk("a_first_vld", 32'(first_vld_cyc - acc_cyc), 32'd3);   // 2 edges after the accept edge
    chk("a_done_time", 32'(done_cyc - acc_cyc), 32'd67);       // 66 edges after the accept edge
    chk("a_last_bot", 32'(last_bot), 32'd2111);

    // Row 31, plane 0: constant words, final bottom read is word 4095
    ram_mode = 1; beats = 0; last_cnt = 0;
    start_req(31, 0);
    run_to_done(1'b0);
    chk("b_beats", 32'(beats), 32'd64);
    chk("b_last_bot", 32'(last_bot), 32'd4095);
    chk("b_last_top", 32'(last_top), 32'd2047);

    // Same request under LFSR backpressure
    beats = 0; last_cnt = 0;
    start_req(31, 0);
    run_to_done(1'b1);
    chk("c_beats", 32'(beats), 32'd64);
    chk("c_last_cnt", 32'(last_cnt), 32'd1);
    px_ready = 1'b1;
    tick();

    // Back-to-back rows 5 and 6 with req_valid held high
    ram_mode = 0; beats = 0; last_cnt = 0;
    acc0 = acc_cnt;
    req_row = 5'd5; req_plane = 3'd7; req_valid = 1'b1;
    tick();
    req_row = 5'd6;
    run_to_done(1'b0);
    d1 = done_cyc;
    chk("bb_acc_in_done", 32'(acc_cyc), 32'(d1));
    chk("bb_acc_cnt", 32'(acc_cnt - acc0), 32'd2);
    req_valid = 1'b0;
    run_to_done(1'b0);
    chk("bb_beats", 32'(beats), 32'd128);
    chk("bb_first_vld", 32'(first_vld_cyc - acc_cyc), 32'd3);

    // A request pulse while busy must be ignored
    beats = 0; acc0 = acc_cnt;
    start_req(3, 0);
    repeat (10) tick();
    req_row = 5'd9; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    run_to_done(1'b0);
    chk("ign_acc_cnt", 32'(acc_cnt - acc0), 32'd1);
    chk("ign_beats", 32'(beats), 32'd64);
    chk("ign_last_top", 32'(last_top), 32'd255);

    // Reset in the middle of a row, after beat 20
    beats = 0;
    start_req(10, 2);
    begin
      int n;
      n = 0;
      while (beats < 20 && n < 200) begin tick(); n++; end
      chk("mid_reached", 32'(beats), 32'd20);
    end
    rst = 1'b0;
    #1;
    chk("mid_px_valid", 32'(px_valid), 32'd0);
    chk("mid_req_ready", 32'(req_ready), 32'd1);
    chk("mid_mem_rd", 32'(mem_rd), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) tick();
    chk("mid_no_vld", 32'(px_valid), 32'd0);
    beats = 0; last_cnt = 0;
    start_req(2, 1);
    run_to_done(1'b0);
    chk("post_beats", 32'(beats), 32'd64);
    chk("post_last_top", 32'(last_top), 32'd191);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
